// File: rtl/fifo_uart_tx.sv
`default_nettype none
// =============================================================================
// Module   : fifo_uart_tx
// Drains 16-bit FIFO words onto a UART line as two LSB-first bytes, low byte
// first. Define UART_TX_PARITY_EN to add an even-parity bit to each byte.
// Revision : 1.0
// =============================================================================
module fifo_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int RD_LAT     = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  word_done
);

    localparam logic [15:0] c_DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_LAT_LAST = 16'(RD_LAT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5,
        S_PARITY = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_cnt;
    logic [2:0]            r_bit;
    logic                  r_sel;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_word_done;
    logic [7:0]            w_byte;
    logic                  w_bit_end;
    logic                  w_lat_end;

    assign w_byte    = r_sel ? r_shift[15:8] : r_shift[7:0];
    assign w_bit_end = (r_cnt == c_DIV_LAST);
    assign w_lat_end = (r_cnt == c_LAT_LAST);
    assign word_done = r_word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        fifo_rd = 1'b0;
        tx      = 1'b1;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) w_next = S_REQ;
            end
            S_REQ: begin
                fifo_rd = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (w_lat_end) w_next = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (w_bit_end) w_next = S_DATA;
            end
            S_DATA: begin
                tx = w_byte[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx = ^w_byte;
                if (w_bit_end) w_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) w_next = r_sel ? S_IDLE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The counter serves both the read-latency wait and the baud timing,
    // so the bit-boundary wrap is suppressed while waiting on the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_sel       <= 1'b0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= (r_state == S_STOP) && w_bit_end && r_sel;
            if ((r_state == S_IDLE) || (w_next != r_state) ||
                ((r_state != S_WAIT) && w_bit_end)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == S_START) begin
                r_bit <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit <= r_bit + 3'd1;
            end
            if ((r_state == S_WAIT) && w_lat_end) begin
                r_shift <= fifo_data;
                r_sel   <= 1'b0;
            end else if ((r_state == S_STOP) && w_bit_end && !r_sel) begin
                r_sel <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_fifo_uart_tx
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds words, a UART monitor
// decodes tx and compares against queued expected bytes.
// Revision : 1.0
// =============================================================================
module tb_fifo_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int RD_LAT  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Cycles from the fifo_rd cycle to the word_done cycle.
    localparam int WORD_T = 1 + RD_LAT + 2 * NB * CLK_DIV;

    logic        clk;
    logic        rst;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        word_done;

    int total       = 0;
    int bad         = 0;
    int cyc         = 0;
    int rd_cnt      = 0;
    int wd_cnt      = 0;
    int rd_rise_cyc = 0;
    bit mon_en      = 1'b1;

    logic [15:0] fq[$];
    logic [7:0]  exp_q[$];

    fifo_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .RD_LAT     (RD_LAT),
        .DATA_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: data appears RD_LAT edges after the edge that sees fifo_rd,
    // and is garbage at every other time so a mistimed latch shows up.
    initial begin : fifo_model
        bit          prev;
        logic [15:0] w;
        prev      = 1'b0;
        fifo_data = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (fifo_rd && !prev) begin
                chk("read_nonempty", 32'(fq.size() != 0), 1);
                w    = (fq.size() != 0) ? fq.pop_front() : 16'hDEAD;
                prev = 1'b1;
                @(posedge clk);
                for (int k = 1; k < RD_LAT; k++) @(posedge clk);
                #1 fifo_data = w;
                @(posedge clk);
                #1 fifo_data = 16'hDEAD;
            end else begin
                prev = fifo_rd;
            end
        end
    end

    initial begin
        fifo_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1 fifo_empty = (fq.size() == 0);
        end
    end

    initial begin : ctl_mon
        bit prev;
        int run;
        prev = 1'b0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (fifo_rd && !prev) begin
                rd_cnt++;
                rd_rise_cyc = cyc;
                run = 1;
            end else if (fifo_rd) begin
                run++;
            end else if (prev) begin
                chk("rd_width", run, 1);
            end
            prev = fifo_rd;
            if (word_done) begin
                wd_cnt++;
                chk("word_done_time", cyc - rd_rise_cyc, WORD_T);
            end
        end
    end

    initial begin : uart_mon
        logic [NB-1:0] fb;
        logic [7:0]    e;
        logic [7:0]    got;
        int            errs;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && (tx === 1'b0)) begin
                chk("frame_expected", 32'(exp_q.size() != 0), 1);
                e  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                fb = '1;
                fb[0]   = 1'b0;
                fb[8:1] = e;
`ifdef UART_TX_PARITY_EN
                fb[9] = ^e;
`endif
                errs = 0;
                got  = 8'h00;
                for (int s = 0; s < NB * CLK_DIV; s++) begin
                    if (s > 0) @(negedge clk);
                    if (tx !== fb[s / CLK_DIV]) errs++;
                    if (((s % CLK_DIV) == CLK_DIV / 2) && (s / CLK_DIV >= 1) && (s / CLK_DIV <= 8))
                        got[s / CLK_DIV - 1] = tx;
                end
                chk("uart_byte", 32'(got), 32'(e));
                chk("frame_bits", errs, 0);
            end
        end
    end

    task automatic push(input logic [15:0] w, input bit expect_out);
        fq.push_back(w);
        if (expect_out) begin
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
        end
    endtask

    task automatic wait_idle(input int lim);
        int n;
        bit ok;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || fq.size() != 0 || exp_q.size() != 0) && n < lim);
        ok = !(busy || fq.size() != 0 || exp_q.size() != 0);
        chk("idle_reached", 32'(ok), 1);
    endtask

    task automatic wait_wd(input int lim, output int c);
        c = -100000;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (word_done) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_tx_low(input int lim, output int c);
        c = 100000;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                c = cyc;
                break;
            end
        end
    endtask

    initial begin : main
        int r0;
        int w0;
        int c1;
        int c2;
        int viol;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_word_done", 32'(word_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Empty FIFO stays quiet
        r0   = rd_cnt;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd || !tx || busy) viol++;
        end
        chk("empty_quiet", viol, 0);
        chk("empty_reads", rd_cnt - r0, 0);

        // Single word
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        w0 = wd_cnt;
        push(16'hA55A, 1'b1);
        wait_idle(400);
        chk("single_reads", rd_cnt - r0, 1);
        chk("single_word_done", wd_cnt - w0, 1);

        // Back-to-back words
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        w0 = wd_cnt;
        push(16'h0001, 1'b1);
        push(16'hFFFF, 1'b1);
        wait_wd(400, c1);
        wait_tx_low(100, c2);
        chk("b2b_gap", c2 - c1, 2 + RD_LAT);
        wait_idle(400);
        chk("b2b_reads", rd_cnt - r0, 2);
        chk("b2b_word_done", wd_cnt - w0, 2);

        // FIFO goes empty during WAIT: word still sent, no extra reads
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        push(16'h1234, 1'b1);
        wait_idle(400);
        repeat (50) @(negedge clk);
        chk("wait_empty_reads", rd_cnt - r0, 1);
        chk("wait_empty_busy", 32'(busy), 0);

        // Parity-sensitive word (0x07 odd weight, 0x03 even weight)
        @(posedge clk);
        #1;
        push(16'h0307, 1'b1);
        wait_idle(400);

        // Reset during DATA
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        r0 = rd_cnt;
        w0 = wd_cnt;
        push(16'hC33C, 1'b0);
        repeat (14) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_fifo_rd", 32'(fifo_rd), 0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx || busy) viol++;
        end
        chk("postrst_quiet", viol, 0);
        chk("postrst_reads", rd_cnt - r0, 1);
        chk("postrst_word_done", wd_cnt - w0, 0);
        mon_en = 1'b1;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
